// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART link-layer blocks (RX frame parser and
//   the TX-side packetizer):
//     - HDR0 / HDR1        : the two-byte frame header
//     - ERR_*              : err_code encodings reported with frame_done
//     - H0/H1/LEN/DATA/CSUM: frame parser state encoding
//     - csum_add           : 8-bit running checksum step
//   No ports (package).
package uart_pkg;

    localparam logic [7:0] HDR0 = 8'hEB;
    localparam logic [7:0] HDR1 = 8'h90;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_LINK = 2'd3;

    localparam logic [2:0] H0   = 3'd0;
    localparam logic [2:0] H1   = 3'd1;
    localparam logic [2:0] LEN  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;

    // Checksum is a plain modulo-256 sum; the carry is deliberately dropped.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] value);
        return acc + value;
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// uart_rx_frame_parser_if
//   Bundles the receive-byte strobes coming from the UART transceiver and
//   the payload/status stream going to the command decoder.
//   Signals:
//     rx_data[7:0]   received byte, valid with rx_data_ready
//     rx_data_ready  one-cycle byte strobe
//     rx_err         one-cycle stop-bit error strobe, coincides with rx_data_ready
//     pl_data[7:0]   payload byte
//     pl_valid       one-cycle strobe qualifying pl_data/pl_index
//     pl_index[7:0]  zero-based position of pl_data within the payload
//     pl_len[7:0]    length field of the current frame
//     frame_done     one-cycle end-of-frame strobe (good or bad)
//     frame_ok       1 = checksum good, only meaningful with frame_done
//     err_code[1:0]  failure reason, only meaningful with frame_done
//     busy           parser is inside a frame (not hunting for HDR0)
//   Modports:
//     master : the side that feeds bytes in and consumes the results
//     slave  : the frame parser itself
interface uart_rx_frame_parser_if;

    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_err;

    logic [7:0] pl_data;
    logic       pl_valid;
    logic [7:0] pl_index;
    logic [7:0] pl_len;
    logic       frame_done;
    logic       frame_ok;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data, rx_data_ready, rx_err,
        input  pl_data, pl_valid, pl_index, pl_len,
        input  frame_done, frame_ok, err_code, busy
    );

    modport slave (
        input  rx_data, rx_data_ready, rx_err,
        output pl_data, pl_valid, pl_index, pl_len,
        output frame_done, frame_ok, err_code, busy
    );

endinterface

// File: rtl/uart_idle_timer.sv
// uart_idle_timer
//   Loadable idle counter used to detect silence on the serial link.
//   Ports:
//     clk              system clock
//     rst_n            asynchronous active-low reset
//     clear            forces the count back to zero (highest priority)
//     load             loads load_value into the count
//     load_value       value taken on load
//     enable           advances the count by one per cycle
//     expire           high while enabled and the count sits at LIMIT-1
//   The counter is allowed to wrap; the owner is expected to react to
//   expire and clear it before that matters.
module uart_idle_timer #(
    parameter int LIMIT = 21700,
    parameter int WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Clear beats load beats count, so a byte arriving on the expiry cycle
    // restarts the window instead of letting it fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Parses link frames  HDR0 HDR1 LEN PAYLOAD[LEN] CSUM  out of the UART
//   receive byte stream, forwards payload bytes as they arrive and reports
//   one frame_done per frame that got past the header.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_rx_frame_parser_if.slave (rx_* in, pl_*/frame_*/busy out)
//   All outputs except busy are registered: pl_valid follows the accepted
//   payload byte by one cycle, frame_done follows the terminating byte (or
//   the timeout) by one cycle. Payload already streamed is never retracted;
//   the consumer must only commit it when frame_done arrives with frame_ok.
module uart_rx_frame_parser #(
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 21700,
    parameter logic [7:0] HDR0           = uart_pkg::HDR0,
    parameter logic [7:0] HDR1           = uart_pkg::HDR1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_frame_parser_if.slave  bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0] state;
    logic [7:0] csum;
    logic [7:0] cnt;

    logic [7:0] pl_data;
    logic       pl_valid;
    logic [7:0] pl_index;
    logic [7:0] pl_len;
    logic       frame_done;
    logic       frame_ok;
    logic [1:0] err_code;

    logic       byte_in;
    logic       in_frame;
    logic       timer_clear;
    logic       timer_expire;

    assign byte_in  = bus.rx_data_ready;
    assign in_frame = (state != uart_pkg::H0);

    // The idle window runs from H1 onward and restarts on every byte; in H0
    // the timer is held at zero so a new frame always gets the full window.
    assign timer_clear = byte_in || !in_frame;

    uart_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ('0),
        .enable     (in_frame),
        .expire     (timer_expire)
    );

    // Frame state machine. Strobes default low each cycle; a byte always
    // takes priority over a coincident timer expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= uart_pkg::H0;
            csum       <= '0;
            cnt        <= '0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            pl_index   <= '0;
            pl_len     <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= uart_pkg::ERR_NONE;
        end else begin
            pl_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= uart_pkg::ERR_NONE;

            if (byte_in) begin
                if (bus.rx_err) begin
                    // A corrupted header byte just restarts the hunt; once a
                    // frame is committed the failure must be reported.
                    if (state != uart_pkg::H0 && state != uart_pkg::H1) begin
                        frame_done <= 1'b1;
                        err_code   <= uart_pkg::ERR_LINK;
                    end
                    state <= uart_pkg::H0;
                end else begin
                    case (state)
                        uart_pkg::H0: begin
                            if (bus.rx_data == HDR0) begin
                                state <= uart_pkg::H1;
                            end
                        end
                        uart_pkg::H1: begin
                            // A repeated HDR0 may be the real start of frame.
                            if (bus.rx_data == HDR1) begin
                                state <= uart_pkg::LEN;
                            end else if (bus.rx_data != HDR0) begin
                                state <= uart_pkg::H0;
                            end
                        end
                        uart_pkg::LEN: begin
                            if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                                frame_done <= 1'b1;
                                err_code   <= uart_pkg::ERR_LEN;
                                state      <= uart_pkg::H0;
                            end else begin
                                pl_len <= bus.rx_data;
                                csum   <= bus.rx_data;
                                cnt    <= '0;
                                state  <= uart_pkg::DATA;
                            end
                        end
                        uart_pkg::DATA: begin
                            pl_valid <= 1'b1;
                            pl_data  <= bus.rx_data;
                            pl_index <= cnt;
                            csum     <= uart_pkg::csum_add(csum, bus.rx_data);
                            cnt      <= cnt + 8'd1;
                            if (cnt == pl_len - 8'd1) begin
                                state <= uart_pkg::CSUM;
                            end
                        end
                        uart_pkg::CSUM: begin
                            frame_done <= 1'b1;
                            if (bus.rx_data == csum) begin
                                frame_ok <= 1'b1;
                                err_code <= uart_pkg::ERR_NONE;
                            end else begin
                                frame_ok <= 1'b0;
                                err_code <= uart_pkg::ERR_CSUM;
                            end
                            state <= uart_pkg::H0;
                        end
                        default: begin
                            state <= uart_pkg::H0;
                        end
                    endcase
                end
            end else if (timer_expire) begin
                // Silence after a lone header byte is not worth reporting.
                if (state != uart_pkg::H1) begin
                    frame_done <= 1'b1;
                    err_code   <= uart_pkg::ERR_LINK;
                end
                state <= uart_pkg::H0;
            end
        end
    end

    assign bus.pl_data    = pl_data;
    assign bus.pl_valid   = pl_valid;
    assign bus.pl_index   = pl_index;
    assign bus.pl_len     = pl_len;
    assign bus.frame_done = frame_done;
    assign bus.frame_ok   = frame_ok;
    assign bus.err_code   = err_code;
    assign bus.busy       = in_frame;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser
//   Self-checking bench for uart_rx_frame_parser. Each scenario task drives
//   a byte sequence, pushes the payload and frame results it expects into
//   scoreboard queues, and compares them against what the monitor saw.
//   No ports (top-level bench).
module tb_uart_rx_frame_parser;

    localparam int TIMEOUT = 21700;
    localparam int MAXLEN  = 64;

    logic clk;
    logic rst_n;

    uart_rx_frame_parser_if bus();

    uart_rx_frame_parser #(
        .MAX_LEN        (MAXLEN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HDR0           (8'hEB),
        .HDR1           (8'h90)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // {data, index} for payload events, {ok, err_code} for frame events
    logic [15:0] exp_pl[$];
    logic [15:0] obs_pl[$];
    logic [2:0]  exp_fr[$];
    logic [2:0]  obs_fr[$];

    logic [15:0] pe, po;
    logic [2:0]  fe, fo;
    logic [7:0]  model_csum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: record every payload and frame strobe away from the clock edge
    always @(negedge clk) begin
        if (bus.pl_valid === 1'b1) obs_pl.push_back({bus.pl_data, bus.pl_index});
        if (bus.frame_done === 1'b1) obs_fr.push_back({bus.frame_ok, bus.err_code});
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #800000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        bus.rx_err        = e;
        @(negedge clk);
        bus.rx_data_ready = 1'b0;
        bus.rx_err        = 1'b0;
        bus.rx_data       = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_queues();
        exp_pl.delete();
        obs_pl.delete();
        exp_fr.delete();
        obs_fr.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_data_ready = 1'b0;
        bus.rx_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pl_data, bus.pl_valid, bus.pl_index, bus.pl_len, bus.frame_done,
             bus.frame_ok, bus.err_code, bus.busy} !== 30'd0)
            $display("[TB] FAIL reset_outputs got %h want 0", {bus.pl_data, bus.pl_valid,
                     bus.pl_index, bus.pl_len, bus.frame_done, bus.frame_ok, bus.err_code, bus.busy});
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_queues();
    endtask

    task automatic test_good_frame();
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        checks++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL good_busy got %b want 1", bus.busy);
        else passed++;
        send_byte(8'h03, 0, 1);
        send_byte(8'h11, 0, 1); exp_pl.push_back({8'h11, 8'd0});
        send_byte(8'h22, 0, 1); exp_pl.push_back({8'h22, 8'd1});
        send_byte(8'h33, 0, 1); exp_pl.push_back({8'h33, 8'd2});
        send_byte(8'h69, 0, 3); exp_fr.push_back({1'b1, 2'd0});
        checks++;
        if (bus.pl_len !== 8'd3) $display("[TB] FAIL good_pl_len got %0d want 3", bus.pl_len);
        else passed++;
        checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL good_idle got %b want 0", bus.busy);
        else passed++;
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL good_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL good_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL good_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL good_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_checksum_wrap();
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hEB, 0, 1);
            send_byte(8'h90, 0, 1);
            send_byte(8'h02, 0, 1);
            send_byte(8'hFF, 0, 1); exp_pl.push_back({8'hFF, 8'd0});
            send_byte(8'h02, 0, 1); exp_pl.push_back({8'h02, 8'd1});
            if (k == 0) begin
                send_byte(8'h03, 0, 1); exp_fr.push_back({1'b1, 2'd0});
            end else begin
                send_byte(8'h04, 0, 1); exp_fr.push_back({1'b0, 2'd1});
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL wrap_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL wrap_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL wrap_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL wrap_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_length();
        send_byte(8'hEB, 0, 1); send_byte(8'h90, 0, 1);
        send_byte(8'h00, 0, 2); exp_fr.push_back({1'b0, 2'd2});
        send_byte(8'hEB, 0, 1); send_byte(8'h90, 0, 1);
        send_byte(8'h41, 0, 2); exp_fr.push_back({1'b0, 2'd2});
        // Largest legal length must parse completely
        send_byte(8'hEB, 0, 1); send_byte(8'h90, 0, 1);
        send_byte(8'h40, 0, 0);
        model_csum = 8'h40;
        for (int i = 0; i < MAXLEN; i++) begin
            send_byte(8'(i + 1), 0, 0);
            exp_pl.push_back({8'(i + 1), 8'(i)});
            model_csum = model_csum + 8'(i + 1);
        end
        send_byte(model_csum, 0, 3); exp_fr.push_back({1'b1, 2'd0});
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL len_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL len_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL len_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL len_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_resync();
        send_byte(8'h55, 0, 1);
        send_byte(8'hEB, 0, 1);
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h01, 0, 1);
        send_byte(8'hAA, 0, 1); exp_pl.push_back({8'hAA, 8'd0});
        send_byte(8'hAB, 0, 3); exp_fr.push_back({1'b1, 2'd0});
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL resync_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL resync_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL resync_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL resync_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_timeout();
        int cycles;
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h02, 0, 1);
        send_byte(8'h10, 0, 0); exp_pl.push_back({8'h10, 8'd0});
        exp_fr.push_back({1'b0, 2'd3});
        cycles = 0;
        while (bus.frame_done !== 1'b1 && cycles < TIMEOUT + 100) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles !== TIMEOUT) $display("[TB] FAIL timeout_latency got %0d want %0d", cycles, TIMEOUT);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL timeout_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL timeout_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL timeout_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL timeout_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_rx_err();
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h03, 0, 1);
        send_byte(8'h21, 0, 1); exp_pl.push_back({8'h21, 8'd0});
        send_byte(8'h22, 1, 3); exp_fr.push_back({1'b0, 2'd3});
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL rxerr_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL rxerr_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL rxerr_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL rxerr_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        send_byte(8'hEB, 0, 0); send_byte(8'h90, 0, 0);
        send_byte(8'h01, 0, 0);
        send_byte(8'h5A, 0, 0); exp_pl.push_back({8'h5A, 8'd0});
        send_byte(8'h5B, 0, 0); exp_fr.push_back({1'b1, 2'd0});
        send_byte(8'hEB, 0, 0); send_byte(8'h90, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h01, 0, 0); exp_pl.push_back({8'h01, 8'd0});
        send_byte(8'h02, 0, 0); exp_pl.push_back({8'h02, 8'd1});
        send_byte(8'h05, 0, 3); exp_fr.push_back({1'b1, 2'd0});
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL b2b_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL b2b_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL b2b_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL b2b_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h04, 0, 1);
        send_byte(8'h01, 0, 1);
        send_byte(8'h02, 0, 0);
        checks++;
        if (bus.pl_len !== 8'd4 || bus.busy !== 1'b1)
            $display("[TB] FAIL midrst_pre got len=%0d busy=%b want len=4 busy=1", bus.pl_len, bus.busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pl_data, bus.pl_valid, bus.pl_index, bus.pl_len, bus.frame_done,
             bus.frame_ok, bus.err_code, bus.busy} !== 30'd0)
            $display("[TB] FAIL midrst_outputs got %h want 0", {bus.pl_data, bus.pl_valid,
                     bus.pl_index, bus.pl_len, bus.frame_done, bus.frame_ok, bus.err_code, bus.busy});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_queues();
        send_byte(8'hEB, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h01, 0, 1);
        send_byte(8'h7E, 0, 1); exp_pl.push_back({8'h7E, 8'd0});
        send_byte(8'h7F, 0, 3); exp_fr.push_back({1'b1, 2'd0});
        checks++;
        if (obs_pl.size() !== exp_pl.size()) $display("[TB] FAIL midrst_pl_count got %0d want %0d", obs_pl.size(), exp_pl.size());
        else passed++;
        while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
            pe = exp_pl.pop_front(); po = obs_pl.pop_front(); checks++;
            if (po !== pe) $display("[TB] FAIL midrst_payload got %h want %h", po, pe);
            else passed++;
        end
        checks++;
        if (obs_fr.size() !== exp_fr.size()) $display("[TB] FAIL midrst_fr_count got %0d want %0d", obs_fr.size(), exp_fr.size());
        else passed++;
        while (exp_fr.size() > 0 && obs_fr.size() > 0) begin
            fe = exp_fr.pop_front(); fo = obs_fr.pop_front(); checks++;
            if (fo !== fe) $display("[TB] FAIL midrst_status got %b want %b", fo, fe);
            else passed++;
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_checksum_wrap();
        test_length();
        test_resync();
        test_rx_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
